// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage RISC-V pipeline: registered forwarding selects, stall/flush control, memory-wait FSM with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic [4:0] e_rd,
  input  logic       e_reg_write,
  input  logic       e_mem_read,
  input  logic [4:0] m_rd,
  input  logic       m_reg_write,
  input  logic       pc_src,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic [1:0] r1_solve,
  output logic [1:0] r2_solve,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       stall_e,
  output logic       stall_m,
  output logic       stall_w,
  output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [1:0]  r1_q, r1_d, r2_q, r2_d;

  logic frz, lu, br;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] erd, input logic ewr,
                                         input logic [4:0] mrd, input logic mwr);
    if (ewr && erd != 5'd0 && erd == rs)      return 2'd2;
    else if (mwr && mrd != 5'd0 && mrd == rs) return 2'd1;
    else                                      return 2'd0;
  endfunction

  // Priority frz > pc_src > lu; a branch seen during a freeze is simply reissued once frz drops.
  assign frz = dmem_req & ~dmem_ready;
  assign lu  = e_mem_read && (e_rd != 5'd0) && ((e_rd == d_rs1) || (e_rd == d_rs2));
  assign br  = pc_src & ~frz;

  assign stall_f = frz | (lu & ~pc_src);
  assign stall_d = frz | (lu & ~pc_src);
  assign flush_d = br;
  assign flush_e = ~frz & (pc_src | lu);
  assign stall_e = frz;
  assign stall_m = frz;
  assign stall_w = frz;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    r1_d = r1_q;
    r2_d = r2_q;
    if (flush_e) begin
      r1_d = 2'd0;
      r2_d = 2'd0;
    end else if (!stall_e) begin
      r1_d = fwd_sel(d_rs1, e_rd, e_reg_write, m_rd, m_reg_write);
      r2_d = fwd_sel(d_rs2, e_rd, e_reg_write, m_rd, m_reg_write);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      RUN: begin
        if (frz) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) state_d = RUN;
        else if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
      end
      default: state_d = RUN;
    endcase
    // Error latches on the edge where the wait count reaches the limit.
    if (state_q == MEM_WAIT && !dmem_ready && wait_cnt_d == TIMEOUT_CNT) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
      err_q      <= 1'b0;
      r1_q       <= 2'd0;
      r2_q       <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
    end
  end

  assign r1_solve        = r1_q;
  assign r2_solve        = r2_q;
  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, frz};
    lu_cnt_d    = lu_cnt_q + {31'd0, lu & ~frz & ~pc_src};
    fl_cnt_d    = fl_cnt_q + {31'd0, br};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      lu_cnt_q    <= 32'd0;
      fl_cnt_q    <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      fl_cnt_q    <= fl_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_lu_stalls    = lu_cnt_q;
  assign perf_flushes      = fl_cnt_q;
`endif

endmodule
